qam_byte_tx: RTL and testbench

Framed QAM-4 transmitter that sits upstream of the receive chain (carrier mixer → demodulator → moving-average filters). It accepts bytes over a valid/ready handshake and prepends a fixed preamble. Each byte is split into four 2-bit symbols, MSB pair first. Each symbol is held for SYM_LEN carrier samples and mixed onto a 16-sample-period sin/cos carrier using the same sign convention the demodulator expects: bit1 selects the sin sign, bit0 selects the cos sign, 0 = negated.

---
 rtl/qam_byte_tx.sv | 148 ++++++++++++++
 tb/tb_qam_byte_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_byte_tx.sv
// Framed QAM-4 byte transmitter: fixed preamble, then four 2-bit symbols per byte,
// each held for SYM_LEN samples of a 16-sample sin/cos carrier.
module qam_byte_tx #(
  parameter int unsigned SYM_LEN       = 16,
  parameter int unsigned PREAMBLE_SYMS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] sample_out,
  output logic       sample_valid,
  output logic [1:0] sym_out,
  output logic       busy,
  output logic       underrun
);
  localparam int unsigned    SCW      = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam logic [SCW-1:0] SYM_LAST = SCW'(SYM_LEN - 1);
  localparam logic [7:0]     PRE_LAST = 8'(PREAMBLE_SYMS - 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;
  state_t state, state_nx;

  logic [3:0]     p;
  logic [SCW-1:0] sym_cnt;
  logic [7:0]     pre_cnt;
  logic [1:0]     byte_sym;
  logic [7:0]     shift;
  logic           cur_last;
  logic           filler;
  logic [7:0]     hold_data;
  logic           hold_last;
  logic           full;
  logic           boundary;
  logic           load;
  logic [1:0]     sym;
  logic [7:0]     sample_d;

  function automatic logic signed [8:0] sin9(input logic [3:0] ph);
    logic signed [8:0] q;
    q = 9'sd0;
    case (ph)
      4'd1, 4'd7, 4'd9,  4'd15: q = 9'sd24;
      4'd2, 4'd6, 4'd10, 4'd14: q = 9'sd45;
      4'd3, 4'd5, 4'd11, 4'd13: q = 9'sd58;
      4'd4, 4'd12:              q = 9'sd63;
      default:                  q = 9'sd0;
    endcase
    return ph[3] ? -q : q;
  endfunction

  assign in_ready = ~full;
  assign boundary = sample_en && (sym_cnt == SYM_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE:
        if (sample_en && (p == 4'd15) && full) state_nx = PREAMBLE;
      PREAMBLE:
        if (boundary && (pre_cnt == PRE_LAST)) begin
          state_nx = DATA;
          load     = 1'b1;
        end
      DATA:
        // byte_sym parks at 3 through filler symbols, so a filler boundary rechecks like a byte end
        if (boundary && (byte_sym == 2'd3)) begin
          if (cur_last) state_nx = IDLE;
          else          load     = full;
        end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sym = 2'b00;
    case (state)
      PREAMBLE: sym = pre_cnt[0] ? 2'b00 : 2'b11;
      DATA:     sym = filler ? 2'b00 : shift[7:6];
      default:  sym = 2'b00;
    endcase
    sample_d = '0;
    if (state != IDLE)
      sample_d = 8'((sym[1] ? sin9(p) : -sin9(p)) + (sym[0] ? sin9(p + 4'd4) : -sin9(p + 4'd4)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p            <= '0;
      sym_cnt      <= '0;
      pre_cnt      <= '0;
      byte_sym     <= '0;
      shift        <= '0;
      cur_last     <= 1'b0;
      filler       <= 1'b0;
      hold_data    <= '0;
      hold_last    <= 1'b0;
      full         <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      sym_out      <= '0;
      busy         <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        hold_data <= in_data;
        hold_last <= in_last;
        full      <= 1'b1;
      end else if (load) begin
        full <= 1'b0;
      end
      sample_valid <= sample_en;
      underrun     <= sample_en && (state == DATA) && filler && (sym_cnt == '0);
      if (sample_en) begin
        p          <= p + 4'd1;
        sample_out <= sample_d;
        sym_out    <= sym;
        busy       <= (state != IDLE);
        if ((state == IDLE) || boundary) sym_cnt <= '0;
        else                             sym_cnt <= sym_cnt + SCW'(1);
        if (state == IDLE)                      pre_cnt <= '0;
        else if ((state == PREAMBLE) && boundary) pre_cnt <= pre_cnt + 8'd1;
        if (load) begin
          shift    <= hold_data;
          cur_last <= hold_last;
          byte_sym <= '0;
          filler   <= 1'b0;
        end else if ((state == DATA) && boundary) begin
          if (byte_sym == 2'd3) begin
            filler <= ~cur_last;
          end else begin
            shift    <= {shift[5:0], 2'b00};
            byte_sym <= byte_sym + 2'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_qam_byte_tx.sv
// Bench for qam_byte_tx: directed and randomized frames checked against a
// symbol-list / carrier-table reference model.
module tb_qam_byte_tx;
  localparam int PRE = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_en = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic [1:0] sym_out;
  logic       busy;
  logic       underrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] txq_data[$];
  bit         txq_last[$];
  int         txq_gate[$];
  int         cap_s[$];
  int         cap_sym[$];
  int         und_idx[$];
  logic [7:0] fb[8];
  int         fd[8];

  qam_byte_tx #(.SYM_LEN(16), .PREAMBLE_SYMS(PRE)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .sample_out(sample_out), .sample_valid(sample_valid), .sym_out(sym_out),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic int ref_sin(int ph);
    int q[5];
    q = '{0, 24, 45, 58, 63};
    if (ph <= 4)       return q[ph];
    else if (ph <= 8)  return q[8 - ph];
    else if (ph <= 12) return -q[ph - 8];
    else               return -q[16 - ph];
  endfunction

  function automatic int ref_sample(int s, int ph);
    int sn, cs;
    sn = ref_sin(ph);
    cs = ref_sin((ph + 4) % 16);
    return ((s / 2) != 0 ? sn : -sn) + ((s % 2) != 0 ? cs : -cs);
  endfunction

  function automatic bit en_for(int mode);
    if (mode == 0)      return 1'b1;
    else if (mode == 1) return (cyc % 3) == 0;
    else                return 1'($urandom_range(0, 1));
  endfunction

  // Called at a negedge; drives one cycle, returns at the following negedge.
  task automatic tick(input bit en);
    bit hs;
    sample_en = en;
    if (txq_data.size() > 0 && cap_s.size() >= txq_gate[0]) begin
      in_valid = 1'b1;
      in_data  = txq_data[0];
      in_last  = txq_last[0];
    end else begin
      in_valid = 1'b0;
    end
    hs = in_valid && in_ready;
    @(posedge clk);
    if (hs) begin
      txq_data.delete(0);
      txq_last.delete(0);
      txq_gate.delete(0);
    end
    cyc++;
    @(negedge clk);
    total++;
    assert (sample_valid === en) else begin
      bad++; $error("FAIL sample_valid_track: got %b want %b", sample_valid, en);
    end
    if (sample_valid && busy) begin
      cap_s.push_back(int'($signed(sample_out)));
      cap_sym.push_back(int'(sym_out));
    end
    if (underrun)
      und_idx.push_back((sample_valid && busy && sym_out == 2'b00) ? cap_s.size() - 1 : -1);
  endtask

  task automatic clear_all();
    txq_data.delete(); txq_last.delete(); txq_gate.delete();
    cap_s.delete(); cap_sym.delete(); und_idx.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    total++;
    assert ({in_ready, sample_out, sample_valid, sym_out, busy, underrun} === 14'b1_00000000_0_00_0_0) else begin
      bad++;
      $error("FAIL %s: got rdy=%b out=%0d sv=%b sym=%b busy=%b und=%b want rdy=1 rest 0",
             tag, in_ready, sample_out, sample_valid, sym_out, busy, underrun);
    end
  endtask

  task automatic check_cap(input int idx, input int want, input string tag);
    int got;
    got = (idx < cap_s.size()) ? cap_s[idx] : 9999;
    total++;
    assert (got === want) else begin
      bad++; $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Frame of nb bytes fb[], byte k>0 offered fd[k] samples into byte k-1 (fd<0: immediately).
  task automatic run_frame(input int nb, input int mode, input string tag);
    int exp_sym[$];
    int exp_und[$];
    int start, m, dd, gate, exp_n, budget, got;
    clear_all();
    for (int i = 0; i < PRE; i++) exp_sym.push_back((i % 2 == 0) ? 3 : 0);
    start = PRE * 16;
    for (int k = 0; k < nb; k++) begin
      gate = 0;
      if (k > 0) begin
        dd   = (fd[k] < 0) ? 0 : fd[k];
        gate = (fd[k] < 0) ? 0 : start + fd[k];
        m = 0;
        while (63 + 16 * m <= dd) m++;
        for (int j = 0; j < m; j++) begin
          exp_und.push_back(start + 64 + 16 * j);
          exp_sym.push_back(0);
        end
        start += 64 + 16 * m;
      end
      txq_data.push_back(fb[k]);
      txq_last.push_back(k == nb - 1);
      txq_gate.push_back(gate);
      for (int s = 0; s < 4; s++) exp_sym.push_back((int'(fb[k]) >> (6 - 2 * s)) & 3);
    end
    exp_n  = exp_sym.size() * 16;
    budget = 8 * exp_n + 400;
    while (cap_s.size() < exp_n && budget > 0) begin
      tick(en_for(mode));
      budget--;
    end
    repeat (48) tick(en_for(mode));
    got = cap_s.size();
    total++;
    assert (got === exp_n) else begin
      bad++; $error("FAIL %s_len: got %0d want %0d", tag, got, exp_n);
    end
    for (int i = 0; i < exp_n && i < got; i++) begin
      total++;
      assert (cap_s[i] === ref_sample(exp_sym[i / 16], i % 16)) else begin
        bad++; $error("FAIL %s_sample[%0d]: got %0d want %0d", tag, i, cap_s[i], ref_sample(exp_sym[i / 16], i % 16));
        break;
      end
      total++;
      assert (cap_sym[i] === exp_sym[i / 16]) else begin
        bad++; $error("FAIL %s_sym[%0d]: got %0d want %0d", tag, i, cap_sym[i], exp_sym[i / 16]);
        break;
      end
    end
    got = und_idx.size();
    total++;
    assert (got === exp_und.size()) else begin
      bad++; $error("FAIL %s_und_cnt: got %0d want %0d", tag, got, exp_und.size());
    end
    for (int i = 0; i < exp_und.size() && i < got; i++) begin
      total++;
      assert (und_idx[i] === exp_und[i]) else begin
        bad++; $error("FAIL %s_und_pos: got %0d want %0d", tag, und_idx[i], exp_und[i]);
      end
    end
    total++;
    assert ({in_ready, busy} === 2'b10) else begin
      bad++; $error("FAIL %s_end_idle: got rdy=%b busy=%b want rdy=1 busy=0", tag, in_ready, busy);
    end
  endtask

  initial begin
    int budget;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_vals");
    rst = 1'b1;

    // idle: nothing queued, sample_en held high
    for (int i = 0; i < 64; i++) begin
      tick(1'b1);
      total++;
      assert ({sample_out, sym_out, busy, in_ready} === 12'b00000000_00_0_1) else begin
        bad++; $error("FAIL idle[%0d]: got out=%0d sym=%b busy=%b rdy=%b want 0/0/0/1",
                      i, sample_out, sym_out, busy, in_ready);
      end
    end

    fb[0] = 8'hE4;
    run_frame(1, 0, "single");
    check_cap(0, 63, "first_sample");
    check_cap(2, 90, "pre11_p2");
    check_cap(18, -90, "pre00_p2");
    check_cap(144, -63, "sym10_p0");
    check_cap(164, -63, "sym01_p4");

    fb[0] = 8'h1B; fb[1] = 8'hC0; fd[1] = -1;
    run_frame(2, 0, "b2b");

    fb[0] = 8'h1B; fb[1] = 8'hC0; fd[1] = 72;
    run_frame(2, 0, "late");

    fb[0] = 8'hE4;
    run_frame(1, 1, "sparse_en");
    check_cap(0, 63, "sparse_first");
    check_cap(144, -63, "sparse_sym10");

    // reset in the middle of the third data symbol
    clear_all();
    txq_data.push_back(8'hA5); txq_last.push_back(1'b0); txq_gate.push_back(0);
    txq_data.push_back(8'h3C); txq_last.push_back(1'b1); txq_gate.push_back(0);
    budget = 2000;
    while (cap_s.size() < PRE * 16 + 32 + 3 && budget > 0) begin
      tick(1'b1);
      budget--;
    end
    rst = 1'b0; sample_en = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("midframe_reset");
    clear_all();
    rst = 1'b1;
    fb[0] = 8'h5A;
    run_frame(1, 0, "after_reset");

    for (int f = 0; f < 6; f++) begin
      int nb, mode, c;
      nb   = $urandom_range(1, 4);
      mode = $urandom_range(0, 2);
      for (int k = 0; k < nb; k++) begin
        fb[k] = 8'($urandom_range(0, 255));
        c = $urandom_range(0, 3);
        if (c == 0)      fd[k] = -1;
        else if (c == 1) fd[k] = 0;
        else             fd[k] = 16 * $urandom_range(0, 5) + $urandom_range(4, 11);
      end
      run_frame(nb, mode, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
